// File: rtl/qracc_bus_sequencer.sv
// qracc_bus_sequencer: buffers host CSR requests in a FIFO and replays them one at a time on the bus master port.
// Optional feature macro QRACC_BUS_SEQ_WRITE_ACK_EN: writes also return a zero-data response.
//
// state   | meaning
// IDLE    | pop the FIFO head into the bus registers when one is queued
// ISSUE   | bus_valid_o held with stable addr/data/wen until bus_ready_i
// WAIT_RD | read issued, waiting for rd_data_valid_i or the timeout
// RESP    | rsp_valid_o held with stable data/err until rsp_ready_i
module qracc_bus_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        req_wen_i,
  input  logic [31:0]                 req_addr_i,
  input  logic [31:0]                 req_wdata_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [31:0]                 rsp_data_o,
  output logic                        rsp_err_o,
  output logic                        bus_valid_o,
  input  logic                        bus_ready_i,
  output logic                        bus_wen_o,
  output logic [31:0]                 bus_addr_o,
  output logic [31:0]                 bus_data_o,
  input  logic [31:0]                 rd_data_i,
  input  logic                        rd_data_valid_i,
  output logic                        idle_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  // Down-counter terminal count is zero, so TIMEOUT_CYCLES WAIT_RD cycles elapse before it fires.
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_t;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } entry_t;

  state_t        state;
  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] tmr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign push         = req_valid_i & ~full;
  assign pop          = (state == IDLE) & ~empty;
  assign head         = mem[rd_ptr];
  assign req_ready_o  = ~full;
  assign idle_o       = (state == IDLE) & empty;
  assign fifo_count_o = count;

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{wen: req_wen_i, addr: req_addr_i, wdata: req_wdata_i};
    end
  end

  // Power-of-two depth, so the natural pointer rollover is the modulo wrap.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      bus_valid_o <= 1'b0;
      bus_wen_o   <= 1'b0;
      bus_addr_o  <= '0;
      bus_data_o  <= '0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
      tmr         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            bus_valid_o <= 1'b1;
            bus_wen_o   <= head.wen;
            bus_addr_o  <= head.addr;
            bus_data_o  <= head.wdata;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus_ready_i) begin
            bus_valid_o <= 1'b0;
            if (bus_wen_o) begin
`ifdef QRACC_BUS_SEQ_WRITE_ACK_EN
              rsp_valid_o <= 1'b1;
              rsp_data_o  <= '0;
              rsp_err_o   <= 1'b0;
              state       <= RESP;
`else
              state       <= IDLE;
`endif
            end else begin
              tmr   <= TMR_LOAD;
              state <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          // Data arriving on the timeout cycle still wins.
          if (rd_data_valid_i) begin
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= rd_data_i;
            rsp_err_o   <= 1'b0;
            state       <= RESP;
          end else if (tmr == '0) begin
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b1;
            state       <= RESP;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qracc_bus_sequencer.sv
// Bench for qracc_bus_sequencer: directed scenarios plus randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_qracc_bus_sequencer;

  localparam int FIFO_DEPTH     = 4;
  localparam int TIMEOUT_CYCLES = 15;
  localparam int P_IDLE = 0, P_BUS = 1, P_WAIT = 2, P_RESP = 3;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic req_valid_i = 1'b0, req_wen_i = 1'b0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic bus_ready_i = 1'b0, rsp_ready_i = 1'b0, rd_data_valid_i = 1'b0;
  logic [31:0] rd_data_i = '0;
  logic req_ready_o, rsp_valid_o, rsp_err_o, bus_valid_o, bus_wen_o, idle_o;
  logic [31:0] rsp_data_o, bus_addr_o, bus_data_o;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_o;

  qracc_bus_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wen_i(req_wen_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i), .bus_wen_o(bus_wen_o),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
    .rd_data_i(rd_data_i), .rd_data_valid_i(rd_data_valid_i),
    .idle_o(idle_o), .fifo_count_o(fifo_count_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_assert++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  // Environment knobs set by the main sequence and applied by the driver process.
  bit rnd_en = 0, spur_en = 0, br_force = 0, rr_force = 0;
  int fixed_delay = -1;
  logic [31:0] rd_force = '0;
  int cd = -1;
  logic [31:0] issued[$];

  function automatic int pick_delay();
    case ($urandom_range(0, 7))
      0, 1:    return 0;
      2:       return 1;
      3:       return 3;
      4:       return 13;
      5:       return 14;
      6:       return 15;
      default: return -1;
    endcase
  endfunction

  initial forever begin : env_drive
    logic rv;
    @(posedge clk); #2;
    if (rnd_en) begin
      bus_ready_i = ($urandom_range(0, 9) < 7);
      rsp_ready_i = ($urandom_range(0, 9) < 6);
      rd_data_i   = $urandom;
    end else begin
      bus_ready_i = br_force;
      rsp_ready_i = rr_force;
      rd_data_i   = rd_force;
    end
    rv = 1'b0;
    if (cd == 0) begin rv = 1'b1; cd = -1; end
    else if (cd > 0) cd--;
    if (spur_en && $urandom_range(0, 19) == 0) rv = 1'b1;
    rd_data_valid_i = rv;
  end

  // A read return is scheduled relative to the handshake edge that follows this sample.
  initial forever begin : bus_monitor
    @(negedge clk);
    if (nrst && bus_valid_o && bus_ready_i) begin
      issued.push_back(bus_addr_o);
      if (!bus_wen_o) cd = rnd_en ? pick_delay() : fixed_delay;
    end
  end

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        mq[$];
  req_t        m_cur;
  int          m_phase = P_IDLE;
  int          m_wait  = 0;
  logic [31:0] m_rdata = '0;
  logic        m_err   = 1'b0;
  bit          m_push;

  initial forever begin : ref_model
    @(posedge clk or negedge nrst);
    if (!nrst) begin
      mq.delete();
      m_phase = P_IDLE;
    end else begin
      m_push = req_valid_i && (mq.size() < FIFO_DEPTH);
      case (m_phase)
        P_IDLE: if (mq.size() != 0) begin m_cur = mq.pop_front(); m_phase = P_BUS; end
        P_BUS: if (bus_ready_i) begin
          if (m_cur.wen) begin
`ifdef QRACC_BUS_SEQ_WRITE_ACK_EN
            m_rdata = '0; m_err = 1'b0; m_phase = P_RESP;
`else
            m_phase = P_IDLE;
`endif
          end else begin
            m_wait = 0; m_phase = P_WAIT;
          end
        end
        P_WAIT: begin
          m_wait++;
          if (rd_data_valid_i) begin m_rdata = rd_data_i; m_err = 1'b0; m_phase = P_RESP; end
          else if (m_wait == TIMEOUT_CYCLES) begin m_rdata = '0; m_err = 1'b1; m_phase = P_RESP; end
        end
        default: if (rsp_ready_i) m_phase = P_IDLE;
      endcase
      if (m_push) mq.push_back('{wen: req_wen_i, addr: req_addr_i, wdata: req_wdata_i});
    end
  end

  initial forever begin : compare
    @(negedge clk);
    chk("bus_valid",  32'(bus_valid_o),  32'(m_phase == P_BUS));
    chk("rsp_valid",  32'(rsp_valid_o),  32'(m_phase == P_RESP));
    chk("req_ready",  32'(req_ready_o),  32'(mq.size() < FIFO_DEPTH));
    chk("fifo_count", 32'(fifo_count_o), 32'(mq.size()));
    chk("idle",       32'(idle_o),       32'(m_phase == P_IDLE && mq.size() == 0));
    if (m_phase == P_BUS) begin
      chk("bus_addr", bus_addr_o, m_cur.addr);
      chk("bus_data", bus_data_o, m_cur.wdata);
      chk("bus_wen",  32'(bus_wen_o), 32'(m_cur.wen));
    end
    if (m_phase == P_RESP) begin
      chk("rsp_data", rsp_data_o, m_rdata);
      chk("rsp_err",  32'(rsp_err_o), 32'(m_err));
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge, req_valid_i left high.
  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit acc;
    req_valid_i = 1'b1; req_wen_i = w; req_addr_i = a; req_wdata_i = d;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); acc = req_ready_o;
      @(posedge clk); #1;
      if (acc) return;
    end
    bound_fail("push_accept");
    req_valid_i = 1'b0;
  endtask

  task automatic wait_quiet(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (idle_o) begin @(posedge clk); #1; return; end
    end
    bound_fail("quiet");
    @(posedge clk); #1;
  endtask

  task automatic reset_values(input string p);
    chk({p, "_bus_valid"},  32'(bus_valid_o),  32'd0);
    chk({p, "_bus_wen"},    32'(bus_wen_o),    32'd0);
    chk({p, "_bus_addr"},   bus_addr_o,        32'd0);
    chk({p, "_bus_data"},   bus_data_o,        32'd0);
    chk({p, "_rsp_valid"},  32'(rsp_valid_o),  32'd0);
    chk({p, "_rsp_data"},   rsp_data_o,        32'd0);
    chk({p, "_rsp_err"},    32'(rsp_err_o),    32'd0);
    chk({p, "_req_ready"},  32'(req_ready_o),  32'd1);
    chk({p, "_idle"},       32'(idle_o),       32'd1);
    chk({p, "_fifo_count"}, 32'(fifo_count_o), 32'd0);
  endtask

  initial begin : main
    int vcnt, rcnt, n;
    bit found;
    logic [31:0] a, d;
    logic w, e;

    repeat (3) @(posedge clk);
    #1;
    reset_values("por");
    nrst = 1'b1;
    br_force = 1; rr_force = 1;
    @(posedge clk); #1;

    // Single write, bus ready throughout.
    push(1'b1, 32'h11, 32'h0000_0A21); req_valid_i = 1'b0;
    vcnt = 0; rcnt = 0; a = '0; d = '0; w = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus_valid_o) begin vcnt++; a = bus_addr_o; d = bus_data_o; w = bus_wen_o; end
      if (rsp_valid_o) rcnt++;
    end
    @(posedge clk); #1;
    chk("wr_valid_cycles", 32'(vcnt), 32'd1);
    chk("wr_addr", a, 32'h11);
    chk("wr_data", d, 32'h0000_0A21);
    chk("wr_wen", 32'(w), 32'd1);
`ifdef QRACC_BUS_SEQ_WRITE_ACK_EN
    chk("wr_rsp_cycles", 32'(rcnt), 32'd1);
`else
    chk("wr_rsp_cycles", 32'(rcnt), 32'd0);
`endif

    // Read with nominal one-cycle return.
    fixed_delay = 0; rd_force = 32'h0040_0010;
    push(1'b0, 32'h12, 32'h0); req_valid_i = 1'b0;
    rcnt = 0; d = '0; e = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid_o) begin rcnt++; d = rsp_data_o; e = rsp_err_o; end
    end
    @(posedge clk); #1;
    chk("rd_rsp_cycles", 32'(rcnt), 32'd1);
    chk("rd_data", d, 32'h0040_0010);
    chk("rd_err", 32'(e), 32'd0);

    // Read that never returns, followed by a queued write.
    fixed_delay = -1;
    push(1'b0, 32'h13, 32'h0); push(1'b1, 32'h14, 32'h5); req_valid_i = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_valid_o && bus_ready_i && !bus_wen_o) begin found = 1; break; end
    end
    if (!found) bound_fail("to_handshake");
    n = 0; d = 32'hFFFF_FFFF; e = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); n++;
      if (rsp_valid_o) begin d = rsp_data_o; e = rsp_err_o; break; end
    end
    chk("to_latency_samples", 32'(n), 32'(TIMEOUT_CYCLES + 1));
    chk("to_data", d, 32'h0);
    chk("to_err", 32'(e), 32'd1);
    found = 0; a = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_valid_o) begin found = 1; a = bus_addr_o; break; end
    end
    if (!found) bound_fail("to_next_issue");
    chk("to_next_addr", a, 32'h14);
    @(posedge clk); #1;
    wait_quiet(100);

    // FIFO fill while the bus stalls.
    br_force = 0;
    @(posedge clk); #1;
    issued.delete();
    push(1'b1, 32'h100, 32'h0);
    for (int k = 1; k <= 4; k++) push(1'b1, 32'h100 + 32'(k), 32'(k));
    req_addr_i = 32'h105; req_wdata_i = 32'h5;
    repeat (3) begin
      @(negedge clk);
      chk("fill_req_ready", 32'(req_ready_o), 32'd0);
      chk("fill_count", 32'(fifo_count_o), 32'd4);
    end
    @(posedge clk); #1;
    br_force = 1;
    push(1'b1, 32'h105, 32'h5); req_valid_i = 1'b0;
    wait_quiet(100);
    chk("fill_issued_n", 32'(issued.size()), 32'd6);
    for (int k = 0; k < 6 && k < issued.size(); k++) chk("fill_order", issued[k], 32'h100 + 32'(k));

    // Reset during WAIT_RD with two writes queued.
    fixed_delay = -1;
    push(1'b0, 32'h200, 32'h0); push(1'b1, 32'h201, 32'h1); push(1'b1, 32'h202, 32'h2);
    req_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_count", 32'(fifo_count_o), 32'd2);
    nrst = 1'b0;
    #1;
    reset_values("mid");
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    vcnt = 0; rcnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus_valid_o) vcnt++;
      if (rsp_valid_o) rcnt++;
    end
    chk("post_rst_bus", 32'(vcnt), 32'd0);
    chk("post_rst_rsp", 32'(rcnt), 32'd0);
    @(posedge clk); #1;
    fixed_delay = 0; rd_force = 32'hCAFE_0034;
    push(1'b0, 32'h300, 32'h0); req_valid_i = 1'b0;
    found = 0; d = '0; e = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid_o) begin found = 1; d = rsp_data_o; e = rsp_err_o; break; end
    end
    if (!found) bound_fail("post_rst_rsp_wait");
    chk("post_rst_data", d, 32'hCAFE_0034);
    chk("post_rst_err", 32'(e), 32'd0);
    @(posedge clk); #1;
    wait_quiet(100);

`ifdef QRACC_BUS_SEQ_WRITE_ACK_EN
    // Write acknowledge held off by the host.
    rr_force = 0;
    push(1'b1, 32'h400, 32'h0); push(1'b1, 32'h401, 32'h1); req_valid_i = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid_o) begin found = 1; break; end
    end
    if (!found) bound_fail("wack_rsp_wait");
    repeat (3) begin
      @(negedge clk);
      chk("wack_valid", 32'(rsp_valid_o), 32'd1);
      chk("wack_data", rsp_data_o, 32'h0);
      chk("wack_err", 32'(rsp_err_o), 32'd0);
      chk("wack_no_issue", 32'(bus_valid_o), 32'd0);
      chk("wack_count", 32'(fifo_count_o), 32'd1);
    end
    @(posedge clk); #1;
    rr_force = 1;
    found = 0; a = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_valid_o) begin found = 1; a = bus_addr_o; break; end
    end
    if (!found) bound_fail("wack_next_issue");
    chk("wack_next_addr", a, 32'h401);
    @(posedge clk); #1;
    wait_quiet(100);
`endif

    // Randomized traffic, checked by the model every cycle.
    rnd_en = 1; spur_en = 1;
    for (int k = 0; k < 300; k++) begin
      push(1'($urandom_range(0, 1)), $urandom, $urandom);
      req_valid_i = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    req_valid_i = 1'b0;
    rnd_en = 0; spur_en = 0; br_force = 1; rr_force = 1; fixed_delay = 0;
    wait_quiet(500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
